dmem_responder: RTL

//  Memory-side responder for the hart's data-memory request interface, with multi-cycle latency.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/lfsr16.sv | 21 ++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Macro DMEM_RAND_LATENCY_EN widens the latency counter for random extra delay.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 in right-shift form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

`ifdef DMEM_RAND_LATENCY_EN
  localparam int CNT_W = 6;
`else
  localparam int CNT_W = 4;
`endif

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free running, reseeded on rst.
// Only instantiated when DMEM_RAND_LATENCY_EN is defined.
module lfsr16
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_state
);

  logic fb;

  assign fb = ^(o_state & LFSR_TAPS);

  // shift right, feedback enters at the top
  always_ff @(posedge clk) begin
    if (rst) o_state <= LFSR_SEED;
    else     o_state <= {fb, o_state[15:1]};
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request/response.
// Macro DMEM_RAND_LATENCY_EN adds 0..3 random cycles of latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load;

  logic [AW-1:0] req_idx;
  logic          req_ren;
  logic          req_wen;
  logic          req_bad;
  logic [31:0]   req_wdata;
  logic [3:0]    req_mask;

  logic          in_err;
  logic          direct;
  logic          commit;
  logic [AW-1:0] c_idx;
  logic          c_ren;
  logic          c_wen;
  logic          c_err;
  logic [31:0]   c_wdata;
  logic [3:0]    c_mask;
  logic [31:0]   lane;
  logic [31:0]   rdata_d;

  logic [31:0] mem [0:DEPTH_WORDS-1];

`ifdef DMEM_RAND_LATENCY_EN
  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (lfsr)
  );

  assign load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign load = CNT_W'(LATENCY - 1);
`endif

  assign o_req_ready = (state == IDLE);

  assign in_err = (i_req_ren == i_req_wen)
                | (|i_req_addr[1:0])
                | (i_req_mask == 4'h0)
                | ({2'b00, i_req_addr[31:2]} >= 32'(DEPTH_WORDS));

  // a zero load commits on the accept edge itself, using live inputs
  always_comb begin
    direct  = (state == IDLE) && i_req_valid && (load == '0);
    commit  = !rst && (direct || ((state == WAIT) && (cnt == '0)));
    c_idx   = req_idx;
    c_ren   = req_ren;
    c_wen   = req_wen;
    c_err   = req_bad;
    c_wdata = req_wdata;
    c_mask  = req_mask;
    if (direct) begin
      c_idx   = i_req_addr[2 +: AW];
      c_ren   = i_req_ren;
      c_wen   = i_req_wen;
      c_err   = in_err;
      c_wdata = i_req_wdata;
      c_mask  = i_req_mask;
    end
    lane = {{8{c_mask[3]}}, {8{c_mask[2]}},
            {8{c_mask[1]}}, {8{c_mask[0]}}};
    rdata_d = (c_ren && !c_err) ? (mem[c_idx] & lane) : 32'h0;
  end

  // per-lane write on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (commit && c_wen && !c_err && c_mask[n])
        mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
    end
  end

  // request/latency/response state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0;
      o_rsp_err   <= 1'b0;
      req_idx     <= '0;
      req_ren     <= 1'b0;
      req_wen     <= 1'b0;
      req_bad     <= 1'b0;
      req_wdata   <= 32'h0;
      req_mask    <= 4'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_idx   <= i_req_addr[2 +: AW];
            req_ren   <= i_req_ren;
            req_wen   <= i_req_wen;
            req_bad   <= in_err;
            req_wdata <= i_req_wdata;
            req_mask  <= i_req_mask;
            cnt       <= load;
            if (load == '0) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= rdata_d;
              o_rsp_err   <= c_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= rdata_d;
            o_rsp_err   <= c_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'h0;
            o_rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
